sram_req_arbiter: RTL

- Shares one single-port synchronous SRAM between the CPU's instruction-fetch requester (pre-IF/IF) and data requester (EX/MEM).
- Each requester sees a req/addr_ok/data_ok handshake. The block arbitrates grants, drives the SRAM, and routes each response back to the requester that owns it.
- Data has priority. A starvation guard forces an instruction grant after a bounded run of data grants.
- Sits between the pipeline stages and the memory, replacing the separate inst_sram_*/data_sram_* ports.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_pick.sv | 24 ++
 rtl/sram_req_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared encodings and widths for the instruction/data SRAM arbiter.
// Owner/state enums plus counter widths sized for MEM_LAT<=4 and STARVE_LIM<=15.
package sram_arb_pkg;

    localparam int CNT_W    = 3;
    localparam int STREAK_W = 4;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant decision: data first, instruction forced once the data streak hits its limit.
// Purely combinational, no latency; grants nothing while the accept window is closed.
module sram_arb_pick (
    input  logic inst_req,
    input  logic data_req,
    input  logic window,
    input  logic streak_at_lim,
    output logic gnt_inst,
    output logic gnt_data
);

    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (window) begin
            if (data_req && !(inst_req && streak_at_lim)) begin
                gnt_data = 1'b1;
            end else if (inst_req) begin
                gnt_inst = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one single-port SRAM between instruction and data requesters, one transaction in flight.
// Grant is combinational; response MEM_LAT cycles later; a requester is stalled by withholding addr_ok.
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0]    LAT_C = CNT_W'(MEM_LAT);
    localparam logic [STREAK_W-1:0] LIM_C = STREAK_W'(STARVE_LIM);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    owner_e               own_q, own_d;
    logic                 wr_q, wr_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;

    logic resp;
    logic window;
    logic streak_at_lim;
    logic gnt_inst;
    logic gnt_data;

    assign resp          = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
    // Gating with resetn keeps every output low while reset is held, even with req asserted.
    assign window        = resetn && ((state_q == ST_IDLE) || resp);
    assign streak_at_lim = (streak_q == LIM_C);

    sram_arb_pick u_pick (
        .inst_req      (inst_req),
        .data_req      (data_req),
        .window        (window),
        .streak_at_lim (streak_at_lim),
        .gnt_inst      (gnt_inst),
        .gnt_data      (gnt_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        own_d    = own_q;
        wr_d     = wr_q;
        streak_d = streak_q;

        if (gnt_inst || gnt_data) begin
            state_d = ST_BUSY;
            cnt_d   = LAT_C;
            own_d   = gnt_data ? OWN_DATA : OWN_INST;
            wr_d    = gnt_data && data_wr;
        end else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (resp) begin
                state_d = ST_IDLE;
            end
        end

        // The streak only measures how long inst has actually been waiting.
        if (!inst_req || gnt_inst) begin
            streak_d = '0;
        end else if (gnt_data && !streak_at_lim) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_comb begin
        inst_addr_ok = gnt_inst;
        data_addr_ok = gnt_data;
        inst_data_ok = resp && (own_q == OWN_INST);
        data_data_ok = resp && (own_q == OWN_DATA);
        inst_rdata   = '0;
        data_rdata   = '0;
        mem_en       = gnt_inst || gnt_data;
        mem_we       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;

        if (inst_data_ok && !wr_q) begin
            inst_rdata = mem_rdata;
        end
        if (data_data_ok && !wr_q) begin
            data_rdata = mem_rdata;
        end

        if (gnt_data) begin
            mem_addr = data_addr;
            if (data_wr) begin
                mem_we = data_wstrb;
            end
        end else if (gnt_inst) begin
            mem_addr = inst_addr;
        end
        if (mem_en) begin
            mem_wdata = data_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            own_q    <= OWN_INST;
            wr_q     <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            own_q    <= own_d;
            wr_q     <= wr_d;
            streak_q <= streak_d;
        end
    end

endmodule
